call_menu_ctrl: RTL and testbench
=================================

CALL_MENU_CTRL -- requirements
Module: call_menu_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, 8, width of peer addresses; N_MAIN, 4, main-menu item count (2..63); MENU_TIMEOUT, 1000, idle cycles before MENU falls back to IDLE; RING_TIMEOUT, 2000, cycles before an unanswered call is auto-rejected.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enter, up, down, left, right  input  1 each  level button inputs, already synchronised to clk.
REQ-005 dial_addr  input  ADDR_W  switch-selected address to dial.
REQ-006 inc_command  input  3  application-layer event: 0 none, 1 CONNECTED, 5 INCOMING, 6 ENDED, 7 REFUSED; other codes ignored.
REQ-007 inc_address  input  ADDR_W  peer address qualifying INCOMING.
REQ-008 command  output  3  request to application layer: 0 none, 1 DIAL, 2 ACCEPT, 3 REJECT, 4 HANGUP.
REQ-009 cmd_valid  output  1  one-cycle strobe qualifying command/address.
REQ-010 address  output  ADDR_W  peer address of current call or request.
REQ-011 current_state  output  3  FSM state encoding (REQ-014).
REQ-012 current_menu_item  output  6  highlighted item in current state.
REQ-013 call_waiting  output  1  high while a second caller is queued.

Function
REQ-014 States SHALL be WELCOME=0, IDLE=1, MENU=2, DIALING=3, INCOMING=4, BUSY=5, WAITING=6, SWAP=7.
REQ-015 Buttons act on rising edge only (registered previous level); holding a button produces one action.
REQ-016 Simultaneous button edges: only highest priority acted on (enter > up > down > left > right); others discarded.
REQ-017 Priority per cycle: reset > inc_command > buttons; a button edge coinciding with a valid inc_command is discarded.
REQ-018 Item counts: MENU N_MAIN; INCOMING 3 (0 caller ID, 1 accept, 2 reject); BUSY 2 (0 caller ID, 1 end call); WAITING 3 (0 waiting ID, 1 swap, 2 reject waiting); others 1.
REQ-019 down increments, up decrements current_menu_item, wrapping modulo item count; every state entry sets item to 0.
REQ-020 WELCOME: enter -> IDLE. IDLE: right -> MENU. MENU: left -> IDLE; enter on item 0 -> DIALING, command DIAL, address=dial_addr; other items no action.
REQ-021 MENU_TIMEOUT consecutive cycles in MENU without a button edge -> IDLE; counter clears on any edge or entry.
REQ-022 DIALING: CONNECTED -> BUSY; REFUSED -> IDLE; left -> HANGUP, IDLE.
REQ-023 INCOMING from IDLE, MENU or DIALING on INCOMING (DIALING first issues HANGUP that cycle); address=inc_address; RING_TIMEOUT cycles start.
REQ-024 INCOMING: enter item 1 -> ACCEPT, BUSY; enter item 2 or ring timeout -> REJECT, IDLE; ENDED -> IDLE, no command.
REQ-025 BUSY: enter item 1 -> HANGUP, remain BUSY until ENDED; ENDED -> IDLE; INCOMING -> WAITING, waiting address latched, call_waiting=1, address unchanged.
REQ-026 WAITING: enter item 2 -> REJECT with waiting address, BUSY; enter item 1 -> HANGUP current address, SWAP.
REQ-027 SWAP lasts exactly one cycle: ACCEPT with waiting address, address<=waiting address, call_waiting=0, -> BUSY.
REQ-028 WAITING on ENDED (current call) -> INCOMING with waiting address, call_waiting=0, ring timer restarted.
REQ-029 Further INCOMING while WAITING or SWAP -> immediate REJECT with that inc_address; state unchanged.
REQ-030 At most one command per cycle; cmd_valid high exactly one cycle per command; command returns to 0 the next cycle.

Reset
REQ-031 reset SHALL set current_state=WELCOME, current_menu_item=0, command=0, cmd_valid=0, address=0, call_waiting=0, all timers and edge registers 0.
REQ-032 Reset asserted mid-call or mid-SWAP aborts without issuing any command.

Verification
REQ-033 enter, right, inc_command=5 inc_address=8'h2A, down, enter -> states 0,1,2,4,5; ACCEPT strobe, address=2A.
REQ-034 BUSY, down, enter, inc_command=6 -> HANGUP strobe one cycle, then IDLE, item 0.
REQ-035 MENU, no buttons MENU_TIMEOUT cycles -> IDLE exactly at count; button at count-1 keeps MENU.
REQ-036 BUSY addr 2A, INCOMING 3B -> WAITING, call_waiting=1; down, enter -> HANGUP 2A, next cycle ACCEPT 3B, BUSY, address=3B.
REQ-037 MENU item N_MAIN-1, down -> item 0; up at 0 -> N_MAIN-1; up+down same edge -> decrement only.
REQ-038 INCOMING, no input RING_TIMEOUT cycles -> REJECT strobe, IDLE.

Source files
------------

// File: rtl/call_menu_ctrl.sv
// Call-handling menu controller: button-driven menu navigation plus call setup,
// call waiting and swap sequencing towards an application layer.
module call_menu_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int N_MAIN       = 4,
  parameter int MENU_TIMEOUT = 1000,
  parameter int RING_TIMEOUT = 2000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enter,
  input  logic              up,
  input  logic              down,
  input  logic              left,
  input  logic              right,
  input  logic [ADDR_W-1:0] dial_addr,
  input  logic [2:0]        inc_command,
  input  logic [ADDR_W-1:0] inc_address,
  output logic [2:0]        command,
  output logic              cmd_valid,
  output logic [ADDR_W-1:0] address,
  output logic [2:0]        current_state,
  output logic [5:0]        current_menu_item,
  output logic              call_waiting
);

  localparam int MW = $clog2(MENU_TIMEOUT + 1);
  localparam int RW = $clog2(RING_TIMEOUT + 1);

  localparam logic [2:0] INC_CONNECTED = 3'd1;
  localparam logic [2:0] INC_INCOMING  = 3'd5;
  localparam logic [2:0] INC_ENDED     = 3'd6;
  localparam logic [2:0] INC_REFUSED   = 3'd7;

  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_DIAL   = 3'd1;
  localparam logic [2:0] CMD_ACCEPT = 3'd2;
  localparam logic [2:0] CMD_REJECT = 3'd3;
  localparam logic [2:0] CMD_HANGUP = 3'd4;

  typedef enum logic [2:0] {
    S_WELCOME  = 3'd0,
    S_IDLE     = 3'd1,
    S_MENU     = 3'd2,
    S_DIALING  = 3'd3,
    S_INCOMING = 3'd4,
    S_BUSY     = 3'd5,
    S_WAITING  = 3'd6,
    S_SWAP     = 3'd7
  } state_t;

  state_t            state_reg, state_next;
  logic [5:0]        item_reg, item_next, nav_item;
  logic [4:0]        prev_btn_reg;
  logic [4:0]        btn, btn_edge;
  logic [MW-1:0]     menu_cnt_reg, menu_cnt_next;
  logic [RW-1:0]     ring_cnt_reg, ring_cnt_next;
  logic [ADDR_W-1:0] call_addr_reg, call_addr_next;
  logic [ADDR_W-1:0] wait_addr_reg, wait_addr_next;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] address_reg, address_next;
  logic              call_waiting_reg, call_waiting_next;
  logic [2:0]        command_reg, command_next;
  logic              cmd_valid_reg;
  logic [5:0]        item_count;
  logic              inc_valid, any_edge;
  logic              act_enter, act_up, act_down, act_left, act_right;

  assign btn = {right, left, down, up, enter};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_edge
      assign btn_edge[gi] = btn[gi] & ~prev_btn_reg[gi];
    end
  endgenerate

  assign any_edge  = |btn_edge;
  assign inc_valid = (inc_command == INC_CONNECTED) || (inc_command == INC_INCOMING) ||
                     (inc_command == INC_ENDED)     || (inc_command == INC_REFUSED);

  // A valid application event in the same cycle swallows all button edges.
  assign act_enter = !inc_valid && btn_edge[0];
  assign act_up    = !inc_valid && !btn_edge[0] && btn_edge[1];
  assign act_down  = !inc_valid && btn_edge[4:2] != 3'b000 && btn_edge[1:0] == 2'b00 && btn_edge[2];
  assign act_left  = !inc_valid && btn_edge[3:0] == 4'b1000;
  assign act_right = !inc_valid && btn_edge[4:0] == 5'b10000;

  always_comb begin
    item_count = 6'd1;
    case (state_reg)
      S_MENU:     item_count = 6'(N_MAIN);
      S_INCOMING: item_count = 6'd3;
      S_BUSY:     item_count = 6'd2;
      S_WAITING:  item_count = 6'd3;
      default:    item_count = 6'd1;
    endcase
  end

  always_comb begin
    nav_item = item_reg;
    if (act_down)
      nav_item = (item_reg == item_count - 6'd1) ? 6'd0 : item_reg + 6'd1;
    else if (act_up)
      nav_item = (item_reg == 6'd0) ? item_count - 6'd1 : item_reg - 6'd1;
  end

  always_comb begin
    state_next        = state_reg;
    menu_cnt_next     = '0;
    ring_cnt_next     = '0;
    call_addr_next    = call_addr_reg;
    wait_addr_next    = wait_addr_reg;
    call_waiting_next = call_waiting_reg;
    command_next      = CMD_NONE;
    req_addr          = call_addr_reg;

    case (state_reg)
      S_WELCOME: begin
        if (act_enter) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (inc_command == INC_INCOMING) begin
          state_next     = S_INCOMING;
          call_addr_next = inc_address;
        end else if (act_right) begin
          state_next = S_MENU;
        end
      end
      S_MENU: begin
        if (inc_command == INC_INCOMING) begin
          state_next     = S_INCOMING;
          call_addr_next = inc_address;
        end else if (any_edge) begin
          if (act_left) begin
            state_next = S_IDLE;
          end else if (act_enter && item_reg == 6'd0) begin
            state_next     = S_DIALING;
            command_next   = CMD_DIAL;
            call_addr_next = dial_addr;
            req_addr       = dial_addr;
          end
        end else if (menu_cnt_reg == MW'(MENU_TIMEOUT - 1)) begin
          state_next = S_IDLE;
        end else begin
          menu_cnt_next = menu_cnt_reg + MW'(1);
        end
      end
      S_DIALING: begin
        if (inc_command == INC_CONNECTED) begin
          state_next = S_BUSY;
        end else if (inc_command == INC_REFUSED) begin
          state_next = S_IDLE;
        end else if (inc_command == INC_INCOMING) begin
          // Drop the outgoing attempt in favour of the caller.
          state_next     = S_INCOMING;
          command_next   = CMD_HANGUP;
          call_addr_next = inc_address;
        end else if (act_left) begin
          state_next   = S_IDLE;
          command_next = CMD_HANGUP;
        end
      end
      S_INCOMING: begin
        ring_cnt_next = ring_cnt_reg + RW'(1);
        if (inc_command == INC_ENDED) begin
          state_next = S_IDLE;
        end else if (ring_cnt_reg == RW'(RING_TIMEOUT - 1)) begin
          state_next   = S_IDLE;
          command_next = CMD_REJECT;
        end else if (act_enter && item_reg == 6'd1) begin
          state_next   = S_BUSY;
          command_next = CMD_ACCEPT;
        end else if (act_enter && item_reg == 6'd2) begin
          state_next   = S_IDLE;
          command_next = CMD_REJECT;
        end
      end
      S_BUSY: begin
        if (inc_command == INC_ENDED) begin
          state_next = S_IDLE;
        end else if (inc_command == INC_INCOMING) begin
          state_next        = S_WAITING;
          wait_addr_next    = inc_address;
          call_waiting_next = 1'b1;
        end else if (act_enter && item_reg == 6'd1) begin
          command_next = CMD_HANGUP;
        end
      end
      S_WAITING: begin
        if (inc_command == INC_ENDED) begin
          state_next        = S_INCOMING;
          call_addr_next    = wait_addr_reg;
          call_waiting_next = 1'b0;
        end else if (inc_command == INC_INCOMING) begin
          command_next = CMD_REJECT;
          req_addr     = inc_address;
        end else if (act_enter && item_reg == 6'd2) begin
          state_next        = S_BUSY;
          command_next      = CMD_REJECT;
          req_addr          = wait_addr_reg;
          call_waiting_next = 1'b0;
        end else if (act_enter && item_reg == 6'd1) begin
          state_next   = S_SWAP;
          command_next = CMD_HANGUP;
        end
      end
      S_SWAP: begin
        // A third caller takes this cycle's command slot; the accept follows next cycle.
        if (inc_command == INC_INCOMING) begin
          command_next = CMD_REJECT;
          req_addr     = inc_address;
        end else begin
          state_next        = S_BUSY;
          command_next      = CMD_ACCEPT;
          req_addr          = wait_addr_reg;
          call_addr_next    = wait_addr_reg;
          call_waiting_next = 1'b0;
        end
      end
      default: state_next = S_WELCOME;
    endcase

    item_next    = (state_next != state_reg) ? 6'd0 : nav_item;
    address_next = (command_next != CMD_NONE) ? req_addr : call_addr_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= S_WELCOME;
      item_reg         <= '0;
      prev_btn_reg     <= '0;
      menu_cnt_reg     <= '0;
      ring_cnt_reg     <= '0;
      call_addr_reg    <= '0;
      wait_addr_reg    <= '0;
      address_reg      <= '0;
      call_waiting_reg <= 1'b0;
      command_reg      <= CMD_NONE;
      cmd_valid_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      item_reg         <= item_next;
      prev_btn_reg     <= btn;
      menu_cnt_reg     <= menu_cnt_next;
      ring_cnt_reg     <= ring_cnt_next;
      call_addr_reg    <= call_addr_next;
      wait_addr_reg    <= wait_addr_next;
      address_reg      <= address_next;
      call_waiting_reg <= call_waiting_next;
      command_reg      <= command_next;
      cmd_valid_reg    <= (command_next != CMD_NONE);
    end
  end

  assign command           = command_reg;
  assign cmd_valid         = cmd_valid_reg;
  assign address           = address_reg;
  assign current_state     = state_reg;
  assign current_menu_item = item_reg;
  assign call_waiting      = call_waiting_reg;

endmodule

// File: tb/tb_call_menu_ctrl.sv
// Directed scenarios plus random traffic for call_menu_ctrl, compared every cycle
// against a cycle-stamp based behavioural model of the call rules.
module tb_call_menu_ctrl;

  localparam int ADDR_W = 8;
  localparam int NM     = 4;
  localparam int MT     = 12;
  localparam int RT     = 16;

  localparam logic [4:0] B_ENTER = 5'b00001;
  localparam logic [4:0] B_UP    = 5'b00010;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_LEFT  = 5'b01000;
  localparam logic [4:0] B_RIGHT = 5'b10000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enter = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [ADDR_W-1:0] dial_addr = '0;
  logic [2:0]        inc_command = '0;
  logic [ADDR_W-1:0] inc_address = '0;
  logic [2:0]        command;
  logic              cmd_valid;
  logic [ADDR_W-1:0] address;
  logic [2:0]        current_state;
  logic [5:0]        current_menu_item;
  logic              call_waiting;

  int checks = 0;
  int failures = 0;

  // Model state: spec-level variables, timers as cycle stamps.
  int cyc = 0;
  int m_mark = 0;
  int m_state = 0, m_item = 0, m_call = 0, m_wait = 0, m_cw = 0, m_cmd = 0, m_addr = 0;
  logic [4:0] m_prev = '0;

  call_menu_ctrl #(
    .ADDR_W(ADDR_W), .N_MAIN(NM), .MENU_TIMEOUT(MT), .RING_TIMEOUT(RT)
  ) dut (
    .clk(clk), .reset(reset),
    .enter(enter), .up(up), .down(down), .left(left), .right(right),
    .dial_addr(dial_addr), .inc_command(inc_command), .inc_address(inc_address),
    .command(command), .cmd_valid(cmd_valid), .address(address),
    .current_state(current_state), .current_menu_item(current_menu_item),
    .call_waiting(call_waiting)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int items(input int s);
    case (s)
      2:       return NM;
      4:       return 3;
      5:       return 2;
      6:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic model_step();
    logic [4:0] b, e;
    int btn, n, ns, cmd, ra, nc, it, ic, ia;
    bit valid;
    cyc++;
    if (reset) begin
      m_state = 0; m_item = 0; m_call = 0; m_wait = 0; m_cw = 0;
      m_cmd = 0; m_addr = 0; m_prev = '0; m_mark = cyc;
      return;
    end
    ic = int'(inc_command);
    ia = int'(inc_address);
    b = {right, left, down, up, enter};
    e = b & ~m_prev;
    m_prev = b;
    valid = (ic == 1) || (ic == 5) || (ic == 6) || (ic == 7);
    // btn: 0 enter, 1 up, 2 down, 3 left, 4 right; lowest index has priority
    btn = -1;
    if (!valid)
      for (int i = 4; i >= 0; i--) if (e[i]) btn = i;
    n  = items(m_state);
    it = m_item;
    if (btn == 1) it = (it + n - 1) % n;
    else if (btn == 2) it = (it + 1) % n;
    ns = m_state; cmd = 0; nc = m_call; ra = m_call;
    case (m_state)
      0: if (btn == 0) ns = 1;
      1: if (ic == 5) begin ns = 4; nc = ia; end
         else if (btn == 4) ns = 2;
      2: if (ic == 5) begin ns = 4; nc = ia; end
         else begin
           if (e != 0) m_mark = cyc;
           if (btn == 3) ns = 1;
           else if (btn == 0 && m_item == 0) begin
             ns = 3; cmd = 1; nc = int'(dial_addr); ra = nc;
           end else if (e == 0 && cyc - m_mark == MT) ns = 1;
         end
      3: if (ic == 1) ns = 5;
         else if (ic == 7) ns = 1;
         else if (ic == 5) begin cmd = 4; ns = 4; nc = ia; end
         else if (btn == 3) begin cmd = 4; ns = 1; end
      4: if (ic == 6) ns = 1;
         else if (cyc - m_mark == RT) begin cmd = 3; ns = 1; end
         else if (btn == 0 && m_item == 1) begin cmd = 2; ns = 5; end
         else if (btn == 0 && m_item == 2) begin cmd = 3; ns = 1; end
      5: if (ic == 6) ns = 1;
         else if (ic == 5) begin ns = 6; m_wait = ia; m_cw = 1; end
         else if (btn == 0 && m_item == 1) cmd = 4;
      6: if (ic == 6) begin ns = 4; nc = m_wait; m_cw = 0; end
         else if (ic == 5) begin cmd = 3; ra = ia; end
         else if (btn == 0 && m_item == 2) begin cmd = 3; ra = m_wait; m_cw = 0; ns = 5; end
         else if (btn == 0 && m_item == 1) begin cmd = 4; ns = 7; end
      7: if (ic == 5) begin cmd = 3; ra = ia; end
         else begin cmd = 2; ra = m_wait; nc = m_wait; m_cw = 0; ns = 5; end
      default: ns = 0;
    endcase
    if (ns != m_state) begin it = 0; m_mark = cyc; end
    m_state = ns; m_item = it; m_call = nc; m_cmd = cmd;
    m_addr = (cmd != 0) ? ra : nc;
  endtask

  task automatic compare_all();
    check("state", int'(current_state), m_state);
    check("item", int'(current_menu_item), m_item);
    check("command", int'(command), m_cmd);
    check("cmd_valid", int'(cmd_valid), (m_cmd != 0) ? 1 : 0);
    check("address", int'(address), m_addr);
    check("call_waiting", int'(call_waiting), m_cw);
    if (cmd_valid)
      $display("cycle %0d cmd=%0d addr=%02h state=%0d", cyc, command, address, current_state);
  endtask

  task automatic tick(input logic [4:0] b, input logic [2:0] ic, input logic [7:0] ia,
                      input logic rst);
    @(negedge clk);
    {right, left, down, up, enter} = b;
    inc_command = ic;
    inc_address = ia;
    reset = rst;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic press(input logic [4:0] b);
    tick(b, 3'd0, 8'h00, 1'b0);
    tick(5'b0, 3'd0, 8'h00, 1'b0);
  endtask

  initial begin
    dial_addr = 8'h55;
    tick(5'b0, 3'd0, 8'h00, 1'b1);
    tick(5'b0, 3'd0, 8'h00, 1'b1);
    check("rst_state", int'(current_state), 0);
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_address", int'(address), 0);

    // Answer an incoming call from the menu.
    press(B_ENTER);
    check("welcome_to_idle", int'(current_state), 1);
    press(B_RIGHT);
    check("idle_to_menu", int'(current_state), 2);
    tick(5'b0, 3'd5, 8'h2A, 1'b0);
    check("menu_to_incoming", int'(current_state), 4);
    press(B_DOWN);
    tick(B_ENTER, 3'd0, 8'h00, 1'b0);
    check("accept_cmd", int'(command), 2);
    check("accept_addr", int'(address), 8'h2A);
    check("accept_state", int'(current_state), 5);
    tick(5'b0, 3'd0, 8'h00, 1'b0);
    check("accept_strobe_end", int'(cmd_valid), 0);

    // Second caller then swap.
    tick(5'b0, 3'd5, 8'h3B, 1'b0);
    check("waiting_state", int'(current_state), 6);
    check("waiting_flag", int'(call_waiting), 1);
    check("waiting_addr_kept", int'(address), 8'h2A);
    press(B_DOWN);
    tick(B_ENTER, 3'd0, 8'h00, 1'b0);
    check("swap_hangup", int'(command), 4);
    check("swap_hangup_addr", int'(address), 8'h2A);
    tick(5'b0, 3'd0, 8'h00, 1'b0);
    check("swap_accept", int'(command), 2);
    check("swap_accept_addr", int'(address), 8'h3B);
    check("swap_busy", int'(current_state), 5);
    check("swap_flag_clear", int'(call_waiting), 0);

    // Hang up and wait for ENDED.
    press(B_DOWN);
    tick(B_ENTER, 3'd0, 8'h00, 1'b0);
    check("hangup_cmd", int'(command), 4);
    check("hangup_stays_busy", int'(current_state), 5);
    tick(5'b0, 3'd0, 8'h00, 1'b0);
    check("hangup_strobe_end", int'(cmd_valid), 0);
    tick(5'b0, 3'd6, 8'h00, 1'b0);
    check("ended_idle", int'(current_state), 1);
    check("ended_item0", int'(current_menu_item), 0);

    // Menu timeout at exactly MT idle cycles, and a late edge that restarts it.
    tick(B_RIGHT, 3'd0, 8'h00, 1'b0);
    repeat (MT - 1) tick(5'b0, 3'd0, 8'h00, 1'b0);
    check("menu_before_timeout", int'(current_state), 2);
    tick(5'b0, 3'd0, 8'h00, 1'b0);
    check("menu_timeout", int'(current_state), 1);
    tick(B_RIGHT, 3'd0, 8'h00, 1'b0);
    repeat (MT - 1) tick(5'b0, 3'd0, 8'h00, 1'b0);
    tick(B_DOWN, 3'd0, 8'h00, 1'b0);
    check("menu_edge_keeps", int'(current_state), 2);
    repeat (MT - 1) tick(5'b0, 3'd0, 8'h00, 1'b0);
    check("menu_restart_hold", int'(current_state), 2);
    tick(5'b0, 3'd0, 8'h00, 1'b0);
    check("menu_restart_timeout", int'(current_state), 1);

    // Item wrap and up/down priority.
    press(B_RIGHT);
    tick(B_UP, 3'd0, 8'h00, 1'b0);
    check("wrap_up", int'(current_menu_item), NM - 1);
    press(B_DOWN);
    check("wrap_down", int'(current_menu_item), 0);
    tick(B_UP | B_DOWN, 3'd0, 8'h00, 1'b0);
    check("up_over_down", int'(current_menu_item), NM - 1);
    press(B_LEFT);
    check("menu_left_idle", int'(current_state), 1);

    // Ring timeout.
    tick(5'b0, 3'd5, 8'h4C, 1'b0);
    repeat (RT - 1) tick(5'b0, 3'd0, 8'h00, 1'b0);
    check("ring_hold", int'(current_state), 4);
    tick(5'b0, 3'd0, 8'h00, 1'b0);
    check("ring_reject", int'(command), 3);
    check("ring_reject_addr", int'(address), 8'h4C);
    check("ring_idle", int'(current_state), 1);

    // Random traffic against the model.
    for (int k = 0; k < 8000; k++) begin
      logic [4:0] b;
      logic [2:0] ic;
      for (int j = 0; j < 5; j++) b[j] = ($urandom_range(0, 5) == 0);
      ic = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      dial_addr = 8'($urandom);
      tick(b, ic, 8'($urandom), ($urandom_range(0, 799) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
